// File: rtl/qspi_quad_reader.sv
// qspi_quad_reader: Quad I/O Fast Read (0xEB) engine with a 4-entry show-ahead byte FIFO; QSPI_CONT_READ_EN enables continuous-read mode
module qspi_quad_reader #(
  parameter int DUMMY_CYCLES = 4,
  parameter int RD_LAT = 1,
  parameter int CS_HIGH = 4
) (
  input  logic        spiclk,
  input  logic        rstn,
  input  logic        req,
  input  logic [23:0] addr,
  input  logic        stop,
  output logic        busy,
  output logic [7:0]  dout,
  output logic        dvalid,
  input  logic        dready,
  output logic        spiclken,
  output logic        spiss2,
  input  logic [3:0]  spiin,
  output logic [3:0]  spiout,
  output logic        spiz0,
  output logic        spiz1
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, DATA, DRAIN, DESEL} state_t;
  localparam logic [7:0] CMD_BYTE = 8'hEB;
`ifdef QSPI_CONT_READ_EN
  localparam logic [7:0] MODE_BYTE = 8'hA0;
`else
  localparam logic [7:0] MODE_BYTE = 8'hFF;
`endif
  state_t state, state_d, nxt;
  logic [7:0] cnt, cnt_d;
  logic [23:0] addr_q;
  logic stop_q, stop_d, cont, stall, adv, last, dclk, push, pop;
  logic [7:0] fifo [4];
  logic [1:0] wp, rp, infl;
  logic [2:0] fcnt;
  logic [RD_LAT-1:0] pv, pl;
  logic [3:0] hi_q;
  assign stall = ({1'b0, fcnt} + {2'b00, infl}) >= 4'd3;
  assign busy = (state != IDLE) || (fcnt != 3'd0);
  assign dvalid = fcnt != 3'd0;
  assign dout = dvalid ? fifo[rp] : 8'h00;
  assign dclk = (state == DATA) && spiclken;
  assign push = pv[RD_LAT-1] && pl[RD_LAT-1];
  assign pop = dvalid && dready;
  // next state, shift counter and pad drive for each phase
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    stop_d = stop_q;
    nxt = state;
    adv = 1'b0;
    last = 1'b0;
    spiss2 = 1'b1;
    spiclken = 1'b0;
    spiout = 4'h0;
    spiz0 = 1'b1;
    spiz1 = 1'b1;
    case (state)
      IDLE: begin
        spiss2 = 1'b0;
        if (req && !busy) begin
          state_d = cont ? ADDR : CMD;
          cnt_d = '0;
          stop_d = 1'b0;
        end
      end
      CMD: begin
        spiclken = !stall;
        adv = !stall;
        nxt = ADDR;
        last = cnt == 8'd7;
        spiout = {3'b000, CMD_BYTE[3'd7 - cnt[2:0]]};
        spiz0 = 1'b0;
      end
      ADDR: begin
        spiclken = !stall;
        adv = !stall;
        nxt = MODE;
        last = cnt == 8'd5;
        spiout = 4'(addr_q >> (5'd20 - {cnt[2:0], 2'b00}));
        spiz0 = 1'b0;
        spiz1 = 1'b0;
      end
      MODE: begin
        spiclken = !stall;
        adv = !stall;
        nxt = DUMMY;
        last = cnt[0];
        spiout = cnt[0] ? MODE_BYTE[3:0] : MODE_BYTE[7:4];
        spiz0 = 1'b0;
        spiz1 = 1'b0;
      end
      DUMMY: begin
        spiclken = !stall;
        adv = !stall;
        nxt = DATA;
        last = cnt == 8'(DUMMY_CYCLES - 1);
      end
      DATA: begin
        if (!cnt[0] && stall) begin
          if (stop || stop_q) state_d = DRAIN;
        end else begin
          spiclken = 1'b1;
          cnt_d = {7'b0, ~cnt[0]};
          stop_d = stop_q | stop;
          if (cnt[0] && (stop || stop_q)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        spiss2 = 1'b0;
        adv = 1'b1;
        nxt = DESEL;
        last = cnt == 8'(RD_LAT - 1);
      end
      default: begin
        spiss2 = 1'b0;
        adv = 1'b1;
        nxt = IDLE;
        last = cnt == 8'(CS_HIGH - 1);
      end
    endcase
    if (adv) begin
      cnt_d = last ? '0 : cnt + 8'd1;
      if (last) state_d = nxt;
    end
  end
  // FSM state, counter, pending stop and latched address
  always_ff @(posedge spiclk) begin
    if (!rstn) begin
      state <= IDLE;
      cnt <= '0;
      stop_q <= 1'b0;
      addr_q <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      stop_q <= stop_d;
      if (state == IDLE && req && !busy) addr_q <= addr;
    end
  end
`ifdef QSPI_CONT_READ_EN
  // flash stays in continuous-read mode once a full mode byte of 0xA0 has gone out
  always_ff @(posedge spiclk) begin
    if (!rstn) cont <= 1'b0;
    else if (state == MODE && cnt[0] && !stall) cont <= 1'b1;
  end
`else
  assign cont = 1'b0;
`endif
  // read-latency pipeline, nibble capture and FIFO pointers
  always_ff @(posedge spiclk) begin
    if (!rstn) begin
      pv <= '0;
      pl <= '0;
      hi_q <= '0;
      wp <= '0;
      rp <= '0;
      fcnt <= '0;
      infl <= '0;
    end else begin
      pv[0] <= dclk;
      pl[0] <= cnt[0];
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pl[i] <= pl[i-1];
      end
      if (pv[RD_LAT-1] && !pl[RD_LAT-1]) hi_q <= spiin;
      if (push) wp <= wp + 2'd1;
      if (pop) rp <= rp + 2'd1;
      fcnt <= fcnt + 3'(push) - 3'(pop);
      infl <= infl + 2'(dclk && cnt[0]) - 2'(push);
    end
  end
  // FIFO storage needs no reset; dout is masked while empty
  always_ff @(posedge spiclk) begin
    if (push) fifo[wp] <= {hi_q, spiin};
  end
endmodule
